// File: rtl/position_pkg.sv
// position_pkg: shared state/command types and position constants for position_ctrl
// Contents:
//   state_e      MANUAL / SWEEP controller states
//   cmd_e        registered command encoding driven towards the position register
//   POS_WIDTH    default position bus width
//   POS_MAX_LEFT one-hot value of the leftmost position
//   POS_HOME     one-hot value of the home (rightmost) position
package position_pkg;
  localparam int POS_WIDTH = 8;
  localparam logic [POS_WIDTH-1:0] POS_MAX_LEFT = POS_WIDTH'(1) << (POS_WIDTH - 1);
  localparam logic [POS_WIDTH-1:0] POS_HOME = POS_WIDTH'(1);
  typedef enum logic {MANUAL, SWEEP} state_e;
  typedef enum logic [1:0] {CMD_NONE, CMD_L, CMD_R, CMD_HOME} cmd_e;
endpackage

// File: rtl/position_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability debouncer and registered press pulse
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   raw    raw asynchronous button input
//   level  debounced button level
//   press  one-cycle pulse the cycle after level rises
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level_d;
  always_ff @(posedge clk)
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      level_d <= 1'b0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      level_d <= level;
      press <= level & ~level_d;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/position_ctrl.sv
// position_ctrl: button-driven command sequencer for the one-hot LED position register
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   btn_l, btn_r, btn_c, btn_u   raw left / right / mode / home buttons
//   pos                          current one-hot position (bit WIDTH-1 = max left)
//   step_l, step_r, home         one-cycle commands to the position register
//   sweep_mode                   high while in SWEEP
// Optional: POSITION_CTRL_HOLD_REPEAT_EN adds auto-repeat of held L/R in MANUAL.
import position_pkg::*;
module position_ctrl #(
  parameter int WIDTH = POS_WIDTH,
  parameter int DEB_CYCLES = 4,
  parameter int SWEEP_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_l,
  input  logic btn_r,
  input  logic btn_c,
  input  logic btn_u,
  input  logic [WIDTH-1:0] pos,
  output logic step_l,
  output logic step_r,
  output logic home,
  output logic sweep_mode
);
  localparam int TW = $clog2(SWEEP_DIV);
  // rescales the package's leftmost-bit constant to this instance's WIDTH
  localparam logic [WIDTH-1:0] MAX_L = WIDTH'({POS_MAX_LEFT, {WIDTH{1'b0}}} >> POS_WIDTH);
  logic [3:0] raw, lvl, prs;
  logic press_l, press_r, press_c, press_u, valid, at_l, at_r, tick, dir, dir_n, unused_lvl;
  logic [TW-1:0] tick_cnt, tick_n;
  state_e state, state_n;
  cmd_e cmd, cmd_n;
  assign raw = {btn_u, btn_c, btn_r, btn_l};
  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk),
      .rst_n(rst_n),
      .raw(raw[i]),
      .level(lvl[i]),
      .press(prs[i])
    );
  end
  assign {press_u, press_c, press_r, press_l} = prs;
  assign unused_lvl = ^lvl;
  assign valid = (pos != '0) && ((pos & (pos - WIDTH'(1))) == '0);
  assign at_l = |(pos & MAX_L);
  assign at_r = |(pos & WIDTH'(POS_HOME));
  assign tick = (state == SWEEP) && (tick_cnt == TW'(SWEEP_DIV - 1));
  assign step_l = cmd == CMD_L;
  assign step_r = cmd == CMD_R;
  assign home = cmd == CMD_HOME;
  assign sweep_mode = state == SWEEP;
`ifdef POSITION_CTRL_HOLD_REPEAT_EN
  localparam int HW = $clog2(4 * SWEEP_DIV);
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic hold_l, hold_r, hold_l_n, hold_r_n, hold_l_ok, hold_r_ok, rep;
  // a hold survives only while its own button alone stays down in MANUAL
  assign hold_l_ok = hold_l & lvl[0] & ~lvl[1] & (state == MANUAL);
  assign hold_r_ok = hold_r & lvl[1] & ~lvl[0] & (state == MANUAL);
  assign rep = (hold_l_ok | hold_r_ok) && (hold_cnt == HW'(4 * SWEEP_DIV - 1));
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= MANUAL;
      cmd <= CMD_NONE;
      dir <= 1'b0;
      tick_cnt <= '0;
`ifdef POSITION_CTRL_HOLD_REPEAT_EN
      hold_l <= 1'b0;
      hold_r <= 1'b0;
      hold_cnt <= '0;
`endif
    end else begin
      state <= state_n;
      cmd <= cmd_n;
      dir <= dir_n;
      tick_cnt <= tick_n;
`ifdef POSITION_CTRL_HOLD_REPEAT_EN
      hold_l <= hold_l_n;
      hold_r <= hold_r_n;
      hold_cnt <= hold_cnt_n;
`endif
    end
  always_comb begin
    state_n = state;
    dir_n = dir;
    cmd_n = CMD_NONE;
    tick_n = (state == SWEEP && !tick) ? tick_cnt + TW'(1) : '0;
`ifdef POSITION_CTRL_HOLD_REPEAT_EN
    hold_l_n = hold_l_ok;
    hold_r_n = hold_r_ok;
    // after the first repeat, rewind so later repeats come every SWEEP_DIV
    hold_cnt_n = rep ? HW'(3 * SWEEP_DIV) : hold_cnt + HW'(1);
`endif
    if (press_u) begin
      cmd_n = CMD_HOME;
      state_n = MANUAL;
      tick_n = '0;
`ifdef POSITION_CTRL_HOLD_REPEAT_EN
      hold_l_n = 1'b0;
      hold_r_n = 1'b0;
`endif
    end else if (!valid) cmd_n = CMD_HOME;
    else if (press_c) begin
      state_n = (state == MANUAL) ? SWEEP : MANUAL;
      dir_n = (state == MANUAL) ? 1'b1 : dir;
      tick_n = '0;
`ifdef POSITION_CTRL_HOLD_REPEAT_EN
      hold_l_n = 1'b0;
      hold_r_n = 1'b0;
`endif
    end else if (state == MANUAL) begin
      if (press_l ^ press_r) cmd_n = press_l ? (at_l ? CMD_NONE : CMD_L) : (at_r ? CMD_NONE : CMD_R);
`ifdef POSITION_CTRL_HOLD_REPEAT_EN
      if (press_l | press_r) begin
        hold_l_n = press_l & ~press_r;
        hold_r_n = press_r & ~press_l;
        hold_cnt_n = '0;
      end else if (rep) cmd_n = hold_l_ok ? (at_l ? CMD_NONE : CMD_L) : (at_r ? CMD_NONE : CMD_R);
`endif
    end else if (tick) begin
      // bounce at an end: reverse direction and step away on the same tick
      cmd_n = dir ? (at_l ? CMD_R : CMD_L) : (at_r ? CMD_L : CMD_R);
      dir_n = dir ? ~at_l : at_r;
    end
  end
endmodule

// File: tb/tb_position_ctrl.sv
// tb_position_ctrl: directed scoreboard bench for position_ctrl
module tb_position_ctrl;
  import position_pkg::*;
  localparam int WIDTH = 8, DEB = 4, SD = 8, LAT = DEB + 4;
  localparam logic [2:0] E_H = 3'b100, E_L = 3'b010, E_R = 3'b001;
  typedef struct {int cyc; logic [2:0] cmd;} exp_t;
  logic clk = 0, rst_n = 0, btn_l = 0, btn_r = 0, btn_c = 0, btn_u = 0, track = 0, mon_en = 0;
  logic [WIDTH-1:0] pos, pos_r = 8'h01, pos_drv = 8'h01;
  logic step_l, step_r, home, sweep_mode;
  logic [2:0] mon_exp;
  int cyc = 0, checks = 0, errors = 0, c, t0;
  exp_t exp_q[$];
  exp_t ent;
  position_ctrl #(.WIDTH(WIDTH), .DEB_CYCLES(DEB), .SWEEP_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .btn_l(btn_l), .btn_r(btn_r), .btn_c(btn_c), .btn_u(btn_u),
    .pos(pos), .step_l(step_l), .step_r(step_r), .home(home), .sweep_mode(sweep_mode)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // behavioural position register, used when track is set
  always @(posedge clk)
    if (!track) pos_r <= pos_drv;
    else if (home) pos_r <= POS_HOME;
    else if (step_l) pos_r <= pos_r << 1;
    else if (step_r) pos_r <= pos_r >> 1;
  assign pos = track ? pos_r : pos_drv;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic push(input int at, input logic [2:0] cmd);
    exp_q.push_back('{cyc: at, cmd: cmd});
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  always @(negedge clk)
    if (mon_en) begin
      mon_exp = 3'b000;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ent = exp_q.pop_front();
        check($sformatf("missed_cmd@%0d", ent.cyc), 32'd0, 32'd1);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ent = exp_q.pop_front();
        mon_exp = ent.cmd;
      end
      check($sformatf("cmd{h,l,r}@%0d", cyc), {29'd0, home, step_l, step_r}, {29'd0, mon_exp});
    end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    idle(3);
    check("rst_step_l", step_l, 0);
    check("rst_step_r", step_r, 0);
    check("rst_home", home, 0);
    check("rst_sweep", sweep_mode, 0);
    rst_n = 1;
    mon_en = 1;
    idle(4);
    c = cyc; push(c + LAT, E_L);
    btn_l = 1; idle(20); btn_l = 0; idle(12);
    for (int i = 0; i < 14; i++) begin
      btn_l = (i % 2 == 0);
      idle(2);
    end
    c = cyc; push(c + LAT, E_L);
    btn_l = 1; idle(12); btn_l = 0; idle(12);
    pos_drv = 8'h80; idle(1);
    btn_l = 1; idle(10); btn_l = 0; idle(12);
    pos_drv = 8'h01;
    btn_r = 1; idle(10); btn_r = 0; idle(12);
    pos_drv = 8'h10;
    btn_l = 1; btn_r = 1; idle(10); btn_l = 0; btn_r = 0; idle(12);
    c = cyc; push(c + LAT, E_R);
    btn_r = 1; idle(10); btn_r = 0; idle(12);
    c = cyc; push(c + LAT, E_L);
    btn_l = 1; idle(10); btn_l = 0; idle(12);
    pos_drv = 8'h40; idle(1); track = 1;
    c = cyc; t0 = c + LAT;
    for (int k = 1; k <= 13; k++) push(t0 + SD * k, (k == 1 || k >= 9) ? E_L : E_R);
    push(t0 + 105, E_H);
    btn_c = 1;
    wait_cyc(t0 - 1); check("sweep_before", sweep_mode, 0);
    wait_cyc(t0); check("sweep_enter", sweep_mode, 1);
    idle(3); btn_c = 0;
    wait_cyc(t0 + 81); btn_r = 1; idle(10); btn_r = 0;
    wait_cyc(t0 + 97); btn_u = 1;
    wait_cyc(t0 + 104); check("sweep_before_home", sweep_mode, 1);
    wait_cyc(t0 + 105); check("sweep_after_home", sweep_mode, 0);
    btn_u = 0; idle(20);
    c = cyc; t0 = c + LAT; push(t0 + SD, E_L);
    btn_c = 1; idle(10); btn_c = 0;
    wait_cyc(t0 + SD + 4);
    exp_q.delete(); rst_n = 0; idle(2);
    check("midrst_step_l", step_l, 0);
    check("midrst_step_r", step_r, 0);
    check("midrst_home", home, 0);
    check("midrst_sweep", sweep_mode, 0);
    rst_n = 1; idle(20);
    track = 0; pos_drv = 8'h08; idle(2);
    c = cyc; btn_l = 1;
    wait_cyc(c + 6); pos_drv = 8'h00;
    for (int k = 7; k <= 9; k++) push(c + k, E_H);
    wait_cyc(c + 9); pos_drv = 8'h06;
    for (int k = 10; k <= 12; k++) push(c + k, E_H);
    wait_cyc(c + 12); pos_drv = 8'h08; btn_l = 0; idle(12);
`ifdef POSITION_CTRL_HOLD_REPEAT_EN
    pos_drv = 8'h01; idle(1); track = 1;
    c = cyc; push(c + LAT, E_L);
    for (int k = 0; k < 6; k++) push(c + LAT + 4 * SD + SD * k, E_L);
    btn_l = 1; idle(100); btn_l = 0; idle(20);
`endif
    mon_en = 0;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
